// File: rtl/axis_width_down.sv
// AXI-Stream width downconverter: one wide word of RATIO lanes is emitted as RATIO narrow beats, LSB lane first.
// Optional macro AXIS_WIDTH_DOWN_TKEEP_EN adds s_axis_tkeep to truncate the last word of a packet.
module axis_width_down #(
  parameter int DATA_WIDTH = 32,
  parameter int RATIO      = 4
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [DATA_WIDTH*RATIO-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        s_axis_tlast,
`ifdef AXIS_WIDTH_DOWN_TKEEP_EN
  input  logic [RATIO-1:0]            s_axis_tkeep,
`endif
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast
);

  localparam int IDX_W = $clog2(RATIO);
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(RATIO - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [IDX_W-1:0]              r_idx;
  logic [IDX_W-1:0]              w_idx_nxt;
  logic [DATA_WIDTH*RATIO-1:0]   r_data;
  logic                          r_last;
  logic                          w_load;
  logic                          w_is_final;

`ifdef AXIS_WIDTH_DOWN_TKEEP_EN
  logic [IDX_W-1:0] r_final;
  logic [IDX_W-1:0] w_keep_top;
  logic [IDX_W-1:0] w_cap_final;

  // Highest kept lane; an all-zero tkeep falls through to lane 0.
  always_comb begin
    w_keep_top = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (s_axis_tkeep[k]) w_keep_top = IDX_W'(k);
    end
  end

  assign w_cap_final = s_axis_tlast ? w_keep_top : LAST_LANE;
  assign w_is_final  = (r_idx == r_final);
`else
  assign w_is_final  = (r_idx == LAST_LANE);
`endif

  assign m_axis_tdata = r_data[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH];

  // s_axis_tready is gated by aresetn so no word is taken while reset is held.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_load        = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    unique case (r_state)
      IDLE: begin
        s_axis_tready = aresetn;
        if (s_axis_tvalid && aresetn) begin
          w_load      = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = w_is_final && r_last;
        s_axis_tready = aresetn && w_is_final && m_axis_tready;
        if (m_axis_tready) begin
          if (!w_is_final) begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end else if (s_axis_tvalid && aresetn) begin
            w_load    = 1'b1;
            w_idx_nxt = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Payload holding registers carry no reset; validity comes from r_state alone.
  always_ff @(posedge aclk) begin
    if (w_load) begin
      r_data  <= s_axis_tdata;
      r_last  <= s_axis_tlast;
`ifdef AXIS_WIDTH_DOWN_TKEEP_EN
      r_final <= w_cap_final;
`endif
    end
  end

endmodule

// File: tb/tb_axis_width_down.sv
// Self-checking bench for axis_width_down (DATA_WIDTH=8, RATIO=4): queue-based beat model
// checked every cycle, plus literal expectations on the observed beat log.
module tb_axis_width_down;
  localparam int DW = 8;
  localparam int R  = 4;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [DW*R-1:0] s_data = '0;
  logic            s_valid = 1'b0;
  logic            s_last = 1'b0;
  logic            s_ready;
  logic [DW-1:0]   m_data;
  logic            m_valid;
  logic            m_ready = 1'b1;
  logic            m_last;
`ifdef AXIS_WIDTH_DOWN_TKEEP_EN
  logic [R-1:0]    s_keep = '1;
`endif

  always #5 clk = ~clk;

  axis_width_down #(.DATA_WIDTH(DW), .RATIO(R)) dut (
    .aclk          (clk),
    .aresetn       (rstn),
    .s_axis_tdata  (s_data),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .s_axis_tlast  (s_last),
`ifdef AXIS_WIDTH_DOWN_TKEEP_EN
    .s_axis_tkeep  (s_keep),
`endif
    .m_axis_tdata  (m_data),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .m_axis_tlast  (m_last)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t         q[$];
  bit            live = 1'b0;
  bit            accepted = 1'b0;
  logic [DW-1:0] log_d[$];
  logic          log_l[$];
  int            log_c[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", name, got, exp, cyc);
    end
  endtask

  // Upstream may push whenever nothing is pending, or when only the final lane is left and leaves now.
  function automatic bit exp_sready();
    return rstn && (q.size() == 0 || (q.size() == 1 && m_ready));
  endfunction

  task automatic push_word(input logic [DW*R-1:0] d, input logic l);
    int n;
    n = R;
`ifdef AXIS_WIDTH_DOWN_TKEEP_EN
    if (l) begin
      n = 1;
      for (int k = 0; k < R; k++) if (s_keep[k]) n = k + 1;
    end
`endif
    for (int k = 0; k < n; k++) begin
      beat_t b;
      b.d = d[k*DW +: DW];
      b.l = l && (k == n - 1);
      q.push_back(b);
    end
  endtask

  always @(posedge clk) begin
    bit sr;
    cyc++;
    accepted = 1'b0;
    if (!rstn) begin
      q.delete();
      live = 1'b1;
    end else if (live) begin
      sr = exp_sready();
      if (q.size() > 0 && m_ready) void'(q.pop_front());
      if (s_valid && sr) begin
        accepted = 1'b1;
        push_word(s_data, s_last);
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("s_tready", 32'(s_ready), 32'(exp_sready()));
      chk("m_tvalid", 32'(m_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        chk("m_tdata", 32'(m_data), 32'(q[0].d));
        chk("m_tlast", 32'(m_last), 32'(q[0].l));
      end else begin
        chk("m_tlast_idle", 32'(m_last), 32'd0);
      end
      if (rstn && m_valid && m_ready) begin
        log_d.push_back(m_data);
        log_l.push_back(m_last);
        log_c.push_back(cyc);
      end
    end
  end

  task automatic send_word(input logic [DW*R-1:0] d, input logic l, input logic [R-1:0] keep);
    int budget;
    s_data  = d;
    s_last  = l;
`ifdef AXIS_WIDTH_DOWN_TKEEP_EN
    s_keep  = keep;
`else
    if (keep == '0) s_last = l;
`endif
    s_valid = 1'b1;
    budget  = 0;
    do begin
      @(posedge clk);
      #1;
      budget++;
    end while (!accepted && budget < 60);
    if (!accepted) chk("accept_timeout", 32'd0, 32'd1);
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (q.size() > 0 && budget < 100) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (q.size() > 0) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic chk_beat(input string name, input int i, input logic [DW-1:0] d, input logic l);
    if (i < log_d.size()) begin
      chk(name, {23'd0, log_l[i], log_d[i]}, {23'd0, l, d});
    end else begin
      chk({name, "_missing"}, 32'(log_d.size()), 32'(i + 1));
    end
  endtask

  initial begin
    int base;

    // Reset held 3 cycles with upstream valid.
    rstn    = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sready", 32'(s_ready), 32'd0);
    chk("rst_mvalid", 32'(m_valid), 32'd0);
    rstn    = 1'b1;
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_mvalid", 32'(m_valid), 32'd0);
    chk("post_rst_mlast", 32'(m_last), 32'd0);
    chk("post_rst_sready", 32'(s_ready), 32'd1);

    // Single word.
    base = log_d.size();
    send_word(32'h44332211, 1'b1, 4'hF);
    chk("single_latency_mvalid", 32'(m_valid), 32'd1);
    drain();
    chk_beat("single_b0", base + 0, 8'h11, 1'b0);
    chk_beat("single_b1", base + 1, 8'h22, 1'b0);
    chk_beat("single_b2", base + 2, 8'h33, 1'b0);
    chk_beat("single_b3", base + 3, 8'h44, 1'b1);
    if (log_c.size() >= base + 4) chk("single_span", 32'(log_c[base+3] - log_c[base]), 32'd3);

    // Back-to-back words, no bubble.
    base = log_d.size();
    send_word(32'h44332211, 1'b0, 4'hF);
    send_word(32'h88776655, 1'b1, 4'hF);
    drain();
    chk_beat("b2b_b3", base + 3, 8'h44, 1'b0);
    chk_beat("b2b_b4", base + 4, 8'h55, 1'b0);
    chk_beat("b2b_b7", base + 7, 8'h88, 1'b1);
    if (log_c.size() >= base + 8) chk("b2b_span", 32'(log_c[base+7] - log_c[base]), 32'd7);

    // Downstream backpressure pattern 1,0,0.
    base = log_d.size();
    fork
      send_word(32'hDDCCBBAA, 1'b1, 4'hF);
      for (int i = 0; i < 12; i++) begin
        m_ready = (i % 3 == 0);
        @(posedge clk);
        #1;
      end
    join
    m_ready = 1'b1;
    drain();
    chk("bp_count", 32'(log_d.size() - base), 32'd4);
    chk_beat("bp_b0", base + 0, 8'hAA, 1'b0);
    chk_beat("bp_b1", base + 1, 8'hBB, 1'b0);
    chk_beat("bp_b2", base + 2, 8'hCC, 1'b0);
    chk_beat("bp_b3", base + 3, 8'hDD, 1'b1);

    // Reset after two beats discards the rest of the word.
    base = log_d.size();
    send_word(32'h44332211, 1'b1, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_count", 32'(log_d.size() - base), 32'd2);
    chk("midrst_mvalid", 32'(m_valid), 32'd0);
    send_word(32'h0000FFEE, 1'b1, 4'hF);
    drain();
    chk_beat("midrst_b0", base + 2, 8'hEE, 1'b0);
    chk_beat("midrst_b1", base + 3, 8'hFF, 1'b0);
    chk_beat("midrst_b3", base + 5, 8'h00, 1'b1);
    chk("midrst_total", 32'(log_d.size() - base), 32'd6);

`ifdef AXIS_WIDTH_DOWN_TKEEP_EN
    // Truncated final word, then an all-zero tkeep word (one lane), back to back.
    base = log_d.size();
    send_word(32'h00332211, 1'b1, 4'b0111);
    send_word(32'h0D0C0B0A, 1'b1, 4'b0000);
    drain();
    chk("keep_count", 32'(log_d.size() - base), 32'd4);
    chk_beat("keep_b2", base + 2, 8'h33, 1'b1);
    chk_beat("keep_b3", base + 3, 8'h0A, 1'b1);
    if (log_c.size() >= base + 4) chk("keep_nobubble", 32'(log_c[base+3] - log_c[base+2]), 32'd1);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
